// File: rtl/uart_pattern_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pattern_gen_if : request/complete handshake toward the uart transmitter|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface uart_pattern_gen_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_done_tick;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_done_tick
  );
endinterface
`default_nettype wire

// File: rtl/uart_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pattern_gen : periodic burst generator (increment/fixed/walk/LFSR)    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_pattern_gen #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   PERIOD_CYCLES  = 33554432,
  parameter int                   BURST_LEN      = 1,
  parameter logic [DATA_BITS-1:0] START_CHAR     = 8'h30,
  parameter logic [DATA_BITS-1:0] END_CHAR       = 8'h39,
  parameter logic [DATA_BITS-1:0] LFSR_TAPS      = 8'hB8,
  parameter logic [DATA_BITS-1:0] LFSR_SEED      = 8'hA5,
  parameter int                   TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DATA_BITS-1:0] fixed_data,
  uart_pattern_gen_if.master   tx_if,
  output logic                 busy,
  output logic                 ledout,
  output logic [15:0]          bytes_sent,
  output logic                 err_timeout
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [PW-1:0]        PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_BITS-1:0] WALK_INIT    = DATA_BITS'(1);

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           state_q,       state_d;
  logic [PW-1:0]        period_cnt_q,  period_cnt_d;
  logic [TW-1:0]        timeout_cnt_q, timeout_cnt_d;
  logic [BW-1:0]        burst_idx_q,   burst_idx_d;
  logic [1:0]           cur_mode_q,    cur_mode_d;
  logic [DATA_BITS-1:0] pattern_q,     pattern_d;
  logic [DATA_BITS-1:0] tx_data_q,     tx_data_d;
  logic                 ledout_q,      ledout_d;
  logic [15:0]          bytes_sent_q,  bytes_sent_d;
  logic                 err_timeout_q, err_timeout_d;

  logic [DATA_BITS-1:0] start_data;
  logic [DATA_BITS-1:0] pattern_adv;
  logic [TW-1:0]        timeout_inc;
  logic                 burst_last;

  function automatic logic [DATA_BITS-1:0] pattern_init(
    input logic [1:0]           m,
    input logic [DATA_BITS-1:0] cur
  );
    case (m)
      MODE_INC:  return START_CHAR;
      MODE_WALK: return WALK_INIT;
      MODE_LFSR: return LFSR_SEED;
      default:   return cur;
    endcase
  endfunction

  function automatic logic [DATA_BITS-1:0] pattern_next(
    input logic [1:0]           m,
    input logic [DATA_BITS-1:0] v
  );
    case (m)
      MODE_INC:  return (v == END_CHAR) ? START_CHAR : v + DATA_BITS'(1);
      MODE_WALK: return {v[DATA_BITS-2:0], v[DATA_BITS-1]};
      MODE_LFSR: return {v[DATA_BITS-2:0], ^(v & LFSR_TAPS)};
      default:   return v;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      period_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      burst_idx_q   <= '0;
      cur_mode_q    <= MODE_INC;
      pattern_q     <= START_CHAR;
      tx_data_q     <= START_CHAR;
      ledout_q      <= 1'b0;
      bytes_sent_q  <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      burst_idx_q   <= burst_idx_d;
      cur_mode_q    <= cur_mode_d;
      pattern_q     <= pattern_d;
      tx_data_q     <= tx_data_d;
      ledout_q      <= ledout_d;
      bytes_sent_q  <= bytes_sent_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Fixed mode bypasses the pattern register so fixed_data is taken live in START.
  assign start_data  = (cur_mode_q == MODE_FIXED) ? fixed_data : pattern_q;
  assign pattern_adv = pattern_next(cur_mode_q, pattern_q);
  assign timeout_inc = timeout_cnt_q + TW'(1);
  assign burst_last  = ((32'(burst_idx_q) + 32'd1) == 32'(BURST_LEN));

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    burst_idx_d   = burst_idx_q;
    cur_mode_d    = cur_mode_q;
    pattern_d     = pattern_q;
    tx_data_d     = tx_data_q;
    ledout_d      = ledout_q;
    bytes_sent_d  = bytes_sent_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (period_cnt_q == PERIOD_LAST) begin
            period_cnt_d  = '0;
            cur_mode_d    = mode;
            burst_idx_d   = '0;
            timeout_cnt_d = '0;
            state_d       = S_START;
            if (mode != cur_mode_q) begin
              pattern_d = pattern_init(mode, pattern_q);
            end
          end else begin
            period_cnt_d = period_cnt_q + PW'(1);
          end
        end
      end

      S_START: begin
        tx_data_d     = start_data;
        timeout_cnt_d = '0;
        state_d       = S_WAIT;
      end

      S_WAIT: begin
        if (tx_if.tx_done_tick) begin
          pattern_d     = pattern_adv;
          tx_data_d     = (cur_mode_q == MODE_FIXED) ? tx_data_q : pattern_adv;
          ledout_d      = ~ledout_q;
          bytes_sent_d  = bytes_sent_q + 16'd1;
          burst_idx_d   = burst_idx_q + BW'(1);
          timeout_cnt_d = '0;
          state_d       = (burst_last || !enable) ? S_IDLE : S_START;
        end else if (timeout_inc == TIMEOUT_LAST) begin
          err_timeout_d = 1'b1;
          timeout_cnt_d = '0;
          state_d       = S_IDLE;
        end else begin
          timeout_cnt_d = timeout_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_if.tx_start = (state_q == S_START);
    tx_if.tx_data  = (state_q == S_START) ? start_data : tx_data_q;
    busy           = (state_q != S_IDLE);
    ledout         = ledout_q;
    bytes_sent     = bytes_sent_q;
    err_timeout    = err_timeout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_pattern_gen : randomized scoreboard bench for uart_pattern_gen      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_pattern_gen;

  localparam int P  = 4;
  localparam int BL = 12;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  fixed_data = 8'h00;
  logic        busy;
  logic        ledout;
  logic [15:0] bytes_sent;
  logic        err_timeout;

  uart_pattern_gen_if #(.DATA_BITS(8)) u_if ();

  uart_pattern_gen #(
    .DATA_BITS      (8),
    .PERIOD_CYCLES  (P),
    .BURST_LEN      (BL),
    .START_CHAR     (8'h30),
    .END_CHAR       (8'h39),
    .LFSR_TAPS      (8'hB8),
    .LFSR_SEED      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .fixed_data  (fixed_data),
    .tx_if       (u_if),
    .busy        (busy),
    .ledout      (ledout),
    .bytes_sent  (bytes_sent),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  bit         mute = 1'b0;
  int         inject_cnt = 0;

  // Reference model: position within the current mode's sequence.
  int m_mode  = 0;
  int m_pos   = 0;
  int m_bytes = 0;
  int m_err   = 0;

  function automatic logic [7:0] ref_byte(input int md, input int pos, input logic [7:0] fx);
    logic [7:0] v;
    case (md)
      0: return 8'(32'h30 + (pos % 10));
      1: return fx;
      2: return 8'(32'd1 << (pos % 8));
      default: begin
        v = 8'hA5;
        for (int i = 0; i < pos; i++) v = {v[6:0], ^(v & 8'hB8)};
        return v;
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected byte per tx_start, checks stability while waiting.
  initial begin
    logic       prev;
    logic [7:0] last;
    prev = 1'b0;
    last = 8'h30;
    forever begin
      @(negedge clk);
      if (u_if.tx_start) begin
        check("no_back_to_back_start", {31'd0, prev}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: got tx_data %0h with empty scoreboard", u_if.tx_data);
        end else begin
          check("tx_data", {24'd0, u_if.tx_data}, {24'd0, exp_q.pop_front()});
        end
        last = u_if.tx_data;
      end else if (busy) begin
        check("tx_data_stable", {24'd0, u_if.tx_data}, {24'd0, last});
      end
      prev = u_if.tx_start;
    end
  end

  // UART model: random completion delay, optional mute, on-demand stray ticks.
  initial begin
    int d;
    int inject_done;
    inject_done = 0;
    u_if.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && u_if.tx_start && !mute) begin
        d = $urandom_range(1, 5);
        repeat (d) @(posedge clk);
        #1 u_if.tx_done_tick = 1'b1;
        @(posedge clk);
        #1 u_if.tx_done_tick = 1'b0;
      end else if (inject_cnt != inject_done) begin
        inject_done++;
        @(posedge clk);
        #1 u_if.tx_done_tick = 1'b1;
        @(posedge clk);
        #1 u_if.tx_done_tick = 1'b0;
      end
    end
  end

  task automatic wait_start(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (u_if.tx_start) break;
    end
    if (!u_if.tx_start) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_start: no tx_start within %0d cycles", n);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("returns_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_bytes_sent"}, {16'd0, bytes_sent}, 32'(m_bytes % 65536));
    check({tag, "_ledout"}, {31'd0, ledout}, 32'(m_bytes % 2));
    check({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'(m_err));
  endtask

  task automatic check_reset_values();
    check("rst_tx_start", {31'd0, u_if.tx_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ledout", {31'd0, ledout}, 32'd0);
    check("rst_bytes_sent", {16'd0, bytes_sent}, 32'd0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    check("rst_tx_data", {24'd0, u_if.tx_data}, 32'h30);
  endtask

  task automatic run_burst(input int md, input logic [7:0] fx, input int nbytes,
                           input int exp_lat, input int mid_mode);
    int n;
    if (md != m_mode) m_pos = 0;
    m_mode = md;
    for (int i = 0; i < nbytes; i++) exp_q.push_back(ref_byte(md, m_pos + i, fx));
    mode       = 2'(md);
    fixed_data = fx;
    enable     = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      wait_start(n);
      if (b == 0) check("start_latency", 32'(n), 32'(exp_lat));
      if (b == 0 && mid_mode >= 0) mode = 2'(mid_mode);
      if (b == nbytes - 1) enable = 1'b0;
    end
    wait_idle();
    m_pos   += nbytes;
    m_bytes += nbytes;
    check_status("burst");
  endtask

  initial begin
    int n;
    int starts;
    repeat (3) @(negedge clk);
    check_reset_values();

    // Increment wrap across a full burst, first start timed from reset release.
    rst = 1'b0;
    run_burst(0, 8'h00, 12, P, -1);

    // Walking-one, mode input changed mid-burst must not take effect.
    run_burst(2, 8'h00, 9, P, 1);
    run_burst(1, 8'h55, 1, P, -1);
    run_burst(3, 8'h00, 3, P, -1);

    // Enable dropped during byte 2: burst stops after it.
    run_burst(0, 8'h00, 2, P, -1);

    // Timeout: no completion, pattern must not advance.
    mute = 1'b1;
    exp_q.push_back(ref_byte(m_mode, m_pos, 8'h00));
    enable = 1'b1;
    wait_start(n);
    check("timeout_start_latency", 32'(n), 32'(P));
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (err_timeout) break;
    end
    check("timeout_rise_cycles", 32'(n), 32'(TO));
    check("timeout_busy", {31'd0, busy}, 32'd0);
    m_err = 1;
    inject_cnt++;
    repeat (5) @(negedge clk);
    check_status("idle_tick_ignored");
    mute = 1'b0;
    run_burst(0, 8'h00, 2, P, -1);

    // Period counter frozen while disabled in IDLE.
    enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.tx_start) starts++;
    end
    check("disabled_no_start", 32'(starts), 32'd0);
    run_burst(m_mode, fixed_data, 1, P - 2, -1);

    for (int k = 0; k < 6; k++) begin
      run_burst(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(1, BL)),
                P, int'($urandom_range(0, 3)));
    end

    // Reset asserted during START.
    mute = 1'b1;
    if (m_mode != 3) m_pos = 0;
    exp_q.push_back(ref_byte(3, m_pos, 8'h00));
    mode   = 2'd3;
    enable = 1'b1;
    wait_start(n);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check_reset_values();
    m_mode  = 0;
    m_pos   = 0;
    m_bytes = 0;
    m_err   = 0;
    rst  = 1'b0;
    mute = 1'b0;
    run_burst(0, 8'h00, 3, P, -1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
